rgba_row_packer: RTL and testbench
==================================

Name: rgba_row_packer

Overview:
- Upstream stage of the row-based median filter.
- Accepts a raster RGBA pixel stream, one 32-bit pixel per cycle, under a valid/ready handshake.
- Assembles COL pixels into one packed row word and presents complete rows, one per handshake, in the exact row_in layout the filter core consumes.
- Ping-pong row buffers sustain 1 pixel/cycle while the downstream row is held.

Parameters:
- COL, 1920: pixels per row.
- ROW, 1080: rows per frame.
- WIDTH, 8: bits per colour channel.
- RIDX_W, 11: width of row_index; must satisfy 2^RIDX_W >= ROW.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  packer can accept a pixel this cycle.
- pix_data  in  4*WIDTH  pixel, {R,G,B,A}, R most significant.
- pix_sof  in  1  qualifies the current pixel as frame start (row 0, col 0).
- row_valid  out  1  complete row presented.
- row_ready  in  1  downstream takes the row.
- row_data  out  COL*4*WIDTH  packed row; pixel i at bits [COL*4*WIDTH-1-i*4*WIDTH -: 4*WIDTH], so pixel 0 sits at the MSBs.
- row_index  out  RIDX_W  frame row number of the presented row.
- row_last  out  1  presented row is row ROW-1.
- frame_err  out  1  one-cycle pulse on an sof resync.

Behaviour:
- Handshakes:
  - Pixel transfer occurs when pix_valid && pix_ready.
  - Row transfer occurs when row_valid && row_ready.
  - row_data, row_index and row_last hold stable while row_valid=1 and row_ready=0.
- Reset values: row_valid=0, row_index=0, row_last=0, frame_err=0, both banks EMPTY, col_cnt=0, row_cnt=0, pix_ready=1. Inputs are ignored while RST=1.
- Reset mid-operation discards all partial and complete rows immediately. No row handshake completes in the reset cycle.
- Each bank has state EMPTY, FILLING or FULL.
  - The write bank wsel receives pixels; the read bank rsel drives the row outputs.
  - pix_ready = (bank[wsel] != FULL), combinational from registered state only. It never depends on pix_valid.
- Accepted pixel:
  - Written to slot col_cnt of bank[wsel]; col_cnt increments.
  - At col_cnt=COL-1: bank[wsel] becomes FULL and is tagged with row_cnt and (row_cnt==ROW-1).
  - col_cnt then wraps to 0. row_cnt increments, wrapping from ROW-1 to 0. wsel toggles.
- Latency: the last pixel of a row is accepted in cycle t. row_valid=1 in cycle t+1 if the read side was idle; otherwise in the cycle after the prior row's handshake.
- Rows are output strictly in fill order (rsel toggles on each row handshake). Row handshake sets bank[rsel] EMPTY.
- Simultaneous row completion and row handshake in the same cycle: both take effect. The other bank is presented next cycle with no bubble.
- Both banks FULL: pix_ready=0 until the next row handshake. pix_ready=1 again the cycle after it.
- Sustained throughput is 1 pixel/cycle provided row_ready is asserted within COL cycles of row_valid.
- pix_sof on an accepted pixel when (row_cnt,col_cnt) != (0,0):
  - frame_err pulses for 1 cycle.
  - The partial row in bank[wsel] is discarded.
  - The pixel is written as row 0, col 0.
  - FULL rows already queued are still delivered unchanged.
- pix_sof at (0,0): normal, no error.
- Missing pix_sof at (0,0): accepted, no error.
- Alpha byte is packed unchanged; the filter ignores it.
- row_index and row_last are registered tags of the presented bank. No arithmetic is performed beyond the counters.
- Counter widths: col_cnt needs clog2(COL) bits; row_cnt is RIDX_W bits.

Decomposition:
- Shared package median_pkg:
  - COL, ROW, WIDTH, PIX_BITS=4*WIDTH, ROW_BITS=COL*PIX_BITS, RIDX_W.
  - Bank-state encoding EMPTY=2'b00, FILLING=2'b01, FULL=2'b10.
- The filter core is to import the same constants from this package.
- One sub-module, rgba_row_bank, instantiated twice:
  - Holds ROW_BITS of storage, a slot write port, a state register, and the index/last tag.
- The top level holds wsel/rsel, the counters, the handshake logic and the output mux.

Test Plan (bench uses COL=4, ROW=3, WIDTH=8):
- Reset then a 12-pixel frame, values 32'h01010100+n, row_ready=1 → three rows.
  - Row 0 = {32'h01010100,...,32'h01010103}, pixel 0 at the MSBs.
  - row_index 0/1/2, row_last only on row 2.
  - First row_valid appears 1 cycle after pixel 3.
- row_ready=0 throughout a frame → pix_ready drops after the 8th accepted pixel.
  - Raising row_ready for one cycle → pix_ready=1 on the next cycle; row 0 is delivered before row 1.
- Last pixel of row 1 accepted in the same cycle row 0 is handshaken → row 1 valid in the next cycle; no dropped or duplicated row.
- pix_sof on the 3rd pixel of row 1, with row 0 pending → frame_err pulses once.
  - Row 0 is still delivered.
  - The next delivered row has index 0 and starts with the sof pixel.
- RST asserted while row_valid=1 and a bank is FILLING → all outputs return to reset values asynchronously.
  - The next frame packs from col 0, row 0.
- Random pix_valid/row_ready stall patterns over 5 frames → a scoreboard matches every row word, index and last flag against a reference model.

Source files
------------

// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// median_pkg : shared geometry constants and bank-state encoding for the
//              row-based median filter (packer and core).
// Revision   : 1.0
// ============================================================================
package median_pkg;

  localparam int COL      = 1920;
  localparam int ROW      = 1080;
  localparam int WIDTH    = 8;
  localparam int PIX_BITS = 4 * WIDTH;
  localparam int ROW_BITS = COL * PIX_BITS;
  localparam int RIDX_W   = 11;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    FULL    = 2'b10
  } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/rgba_row_bank.sv
`default_nettype none
// ============================================================================
// rgba_row_bank : one row of pixel storage with slot write port, fill state
//                 and the frame-row tag of the row it holds.
// Revision      : 1.0
// ============================================================================
module rgba_row_bank #(
  parameter int COL    = median_pkg::COL,
  parameter int WIDTH  = median_pkg::WIDTH,
  parameter int RIDX_W = median_pkg::RIDX_W,
  parameter int CNT_W  = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_en,
  input  logic [CNT_W-1:0]        wr_slot,
  input  logic [4*WIDTH-1:0]      wr_data,
  input  logic                    wr_commit,
  input  logic [RIDX_W-1:0]       tag_index,
  input  logic                    tag_last,
  input  logic                    clear,
  output median_pkg::bank_state_t state,
  output logic [COL*4*WIDTH-1:0]  row_data,
  output logic [RIDX_W-1:0]       row_index,
  output logic                    row_last
);
  import median_pkg::*;

  localparam int PIX_W = 4 * WIDTH;

  logic [PIX_W-1:0] slots [COL];

  // Pixel storage carries no reset: stale slots are always overwritten
  // before the bank is marked FULL again.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      slots[wr_slot] <= wr_data;
    end
  end

  for (genvar i = 0; i < COL; i++) begin : g_pack
    assign row_data[(COL-i)*PIX_W-1 -: PIX_W] = slots[i];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      row_index <= '0;
      row_last  <= 1'b0;
    end else if (clear) begin
      state <= EMPTY;
    end else if (wr_en) begin
      if (wr_commit) begin
        state     <= FULL;
        row_index <= tag_index;
        row_last  <= tag_last;
      end else begin
        state <= FILLING;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgba_row_packer.sv
`default_nettype none
// ============================================================================
// rgba_row_packer : packs a raster RGBA pixel stream into full rows through
//                   ping-pong banks, presenting one row per handshake.
// Revision        : 1.0
// ============================================================================
module rgba_row_packer #(
  parameter int COL    = median_pkg::COL,
  parameter int ROW    = median_pkg::ROW,
  parameter int WIDTH  = median_pkg::WIDTH,
  parameter int RIDX_W = median_pkg::RIDX_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [4*WIDTH-1:0]     pix_data,
  input  logic                   pix_sof,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [COL*4*WIDTH-1:0] row_data,
  output logic [RIDX_W-1:0]      row_index,
  output logic                   row_last,
  output logic                   frame_err
);
  import median_pkg::*;

  localparam int CNT_W = (COL > 1) ? $clog2(COL) : 1;
  localparam int ROW_W = COL * 4 * WIDTH;

  logic              wsel;
  logic              rsel;
  logic [CNT_W-1:0]  col_cnt;
  logic [RIDX_W-1:0] row_cnt;

  bank_state_t       bank_state [2];
  logic [ROW_W-1:0]  bank_data  [2];
  logic [RIDX_W-1:0] bank_index [2];
  logic              bank_last  [2];

  logic              accept;
  logic              take;
  logic              resync;
  logic              row_done;
  logic              tag_last;
  logic [CNT_W-1:0]  slot;
  logic [RIDX_W-1:0] row_tag;

  assign pix_ready = (bank_state[wsel] != FULL);
  assign accept    = pix_valid && pix_ready;

  // An sof away from (0,0) restarts the current bank at row 0, col 0;
  // already queued FULL rows are untouched.
  assign resync    = accept && pix_sof && ((col_cnt != '0) || (row_cnt != '0));
  assign slot      = resync ? '0 : col_cnt;
  assign row_tag   = resync ? '0 : row_cnt;
  assign row_done  = accept && (slot == CNT_W'(COL - 1));
  assign tag_last  = (row_tag == RIDX_W'(ROW - 1));

  assign row_valid = (bank_state[rsel] == FULL);
  assign take      = row_valid && row_ready;
  assign row_data  = bank_data[rsel];
  assign row_index = bank_index[rsel];
  assign row_last  = bank_last[rsel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);

    rgba_row_bank #(
      .COL    (COL),
      .WIDTH  (WIDTH),
      .RIDX_W (RIDX_W),
      .CNT_W  (CNT_W)
    ) u_bank (
      .CLK       (CLK),
      .RST       (RST),
      .wr_en     (accept && (wsel == SEL)),
      .wr_slot   (slot),
      .wr_data   (pix_data),
      .wr_commit (row_done),
      .tag_index (row_tag),
      .tag_last  (tag_last),
      .clear     (take && (rsel == SEL)),
      .state     (bank_state[b]),
      .row_data  (bank_data[b]),
      .row_index (bank_index[b]),
      .row_last  (bank_last[b])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wsel      <= 1'b0;
      rsel      <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= resync;
      if (take) begin
        rsel <= ~rsel;
      end
      if (accept) begin
        if (row_done) begin
          col_cnt <= '0;
          row_cnt <= tag_last ? '0 : row_tag + RIDX_W'(1);
          wsel    <= ~wsel;
        end else begin
          col_cnt <= slot + CNT_W'(1);
          row_cnt <= row_tag;
        end
      end
    end
  end

  a_row_hold : assert property (
    @(posedge CLK) disable iff (RST)
    (row_valid && !row_ready) |=>
      (row_valid && $stable(row_data) && $stable(row_index) && $stable(row_last))
  );

endmodule
`default_nettype wire

// File: tb/tb_rgba_row_packer.sv
`default_nettype none
// ============================================================================
// tb_rgba_row_packer : directed scenarios plus a randomized scoreboard run
//                      against a row-queue reference model.
// Revision           : 1.0
// ============================================================================
module tb_rgba_row_packer;

  localparam int COL    = 4;
  localparam int ROW    = 3;
  localparam int WIDTH  = 8;
  localparam int RIDX_W = 2;
  localparam int PIX_W  = 4 * WIDTH;
  localparam int ROW_W  = COL * PIX_W;

  typedef struct {
    logic [ROW_W-1:0]  data;
    logic [RIDX_W-1:0] idx;
    logic              last;
  } row_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic              row_ready = 1'b0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              pix_ready;
  logic              row_valid;
  logic              row_last;
  logic              frame_err;
  logic [ROW_W-1:0]  row_data;
  logic [RIDX_W-1:0] row_index;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of complete rows awaiting delivery plus raster position.
  row_t             exp_q[$];
  int               mc;
  int               mr;
  logic             exp_err;
  logic [PIX_W-1:0] part [COL];

  rgba_row_packer #(
    .COL    (COL),
    .ROW    (ROW),
    .WIDTH  (WIDTH),
    .RIDX_W (RIDX_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_index (row_index),
    .row_last  (row_last),
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [PIX_W-1:0] pix(input int n);
    return 32'h01010100 + PIX_W'(n);
  endfunction

  function automatic logic [ROW_W-1:0] seq_row(input int base);
    return {pix(base), pix(base + 1), pix(base + 2), pix(base + 3)};
  endfunction

  task automatic tick();
    bit   acc;
    bit   hs;
    row_t r;
    acc = pix_valid && (exp_q.size() < 2);
    hs  = row_ready && (exp_q.size() > 0);
    @(posedge CLK);
    if (hs) void'(exp_q.pop_front());
    exp_err = 1'b0;
    if (acc) begin
      if (pix_sof && (mr != 0 || mc != 0)) begin
        exp_err = 1'b1;
        mc = 0;
        mr = 0;
      end
      part[mc] = pix_data;
      if (mc == COL - 1) begin
        for (int i = 0; i < COL; i++) r.data[ROW_W-1-i*PIX_W -: PIX_W] = part[i];
        r.idx  = RIDX_W'(mr);
        r.last = (mr == ROW - 1);
        exp_q.push_back(r);
        mc = 0;
        mr = (mr == ROW - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mc = 0;
    mr = 0;
    exp_err = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    row_ready = 1'b0;
    pix_data = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    pix_valid = 1'b1;
    pix_sof = 1'b1;
    row_ready = 1'b1;
    pix_data = 32'hDEADBEEF;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
    tests++; if (row_valid !== 1'b0) begin fails++; $display("FAIL reset_row_valid: got %b want 0", row_valid); end
    tests++; if (row_index !== '0) begin fails++; $display("FAIL reset_row_index: got %0d want 0", row_index); end
    tests++; if (row_last !== 1'b0) begin fails++; $display("FAIL reset_row_last: got %b want 0", row_last); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    do_reset();
  endtask

  task automatic test_basic_frame();
    row_t got[$];
    row_t r;
    do_reset();
    row_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      pix_valid = (n < 12);
      pix_data  = pix(n);
      pix_sof   = (n == 0);
      if (row_valid && row_ready) begin
        r.data = row_data; r.idx = row_index; r.last = row_last;
        got.push_back(r);
      end
      if (n == 3) begin
        tests++; if (row_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", row_valid); end
      end
      tick();
      if (n == 3) begin
        tests++; if (row_valid !== 1'b1) begin fails++; $display("FAIL basic_first_latency: got %b want 1", row_valid); end
      end
    end
    pix_valid = 1'b0;
    tests++; if (got.size() != 3) begin fails++; $display("FAIL basic_row_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++; if (got[i].data !== seq_row(4 * i)) begin fails++; $display("FAIL basic_row_data[%0d]: got %h want %h", i, got[i].data, seq_row(4 * i)); end
      tests++; if (got[i].idx !== RIDX_W'(i)) begin fails++; $display("FAIL basic_row_index[%0d]: got %0d want %0d", i, got[i].idx, i); end
      tests++; if (got[i].last !== (i == 2)) begin fails++; $display("FAIL basic_row_last[%0d]: got %b want %b", i, got[i].last, (i == 2)); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int guard = 0;
    do_reset();
    row_ready = 1'b0;
    while (acc < 8 && guard < 40) begin
      pix_valid = 1'b1;
      pix_data  = pix(acc);
      pix_sof   = (acc == 0);
      if (pix_ready) acc++;
      tick();
      guard++;
    end
    tests++; if (acc != 8) begin fails++; $display("FAIL bp_accept_timeout: got %0d want 8", acc); end
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b want 0", pix_ready); end
    pix_data = pix(8);
    pix_sof  = 1'b0;
    tick();
    tick();
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_held: got %b want 0", pix_ready); end
    tests++; if (row_index !== 2'd0 || row_data !== seq_row(0)) begin fails++; $display("FAIL bp_first_row: got idx %0d data %h want idx 0 data %h", row_index, row_data, seq_row(0)); end
    pix_valid = 1'b0;
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_return: got %b want 1", pix_ready); end
    tests++; if (row_valid !== 1'b1 || row_index !== 2'd1 || row_data !== seq_row(4)) begin fails++; $display("FAIL bp_second_row: got v %b idx %0d data %h want v 1 idx 1 data %h", row_valid, row_index, row_data, seq_row(4)); end
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    tests++; if (row_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", row_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      pix_valid = 1'b1;
      pix_data  = pix(n);
      pix_sof   = (n == 0);
      row_ready = (n == 7);
      if (n == 7) begin
        tests++; if (row_valid !== 1'b1 || row_index !== 2'd0) begin fails++; $display("FAIL simul_row0_present: got v %b idx %0d want v 1 idx 0", row_valid, row_index); end
      end
      tick();
    end
    pix_valid = 1'b0;
    row_ready = 1'b0;
    tests++; if (row_valid !== 1'b1 || row_index !== 2'd1 || row_data !== seq_row(4)) begin fails++; $display("FAIL simul_row1_next: got v %b idx %0d data %h want v 1 idx 1 data %h", row_valid, row_index, row_data, seq_row(4)); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL simul_ready: got %b want 1", pix_ready); end
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    tests++; if (row_valid !== 1'b0) begin fails++; $display("FAIL simul_no_duplicate: got %b want 0", row_valid); end
  endtask

  task automatic test_sof_resync();
    int pulses = 0;
    row_t got[$];
    row_t r;
    logic [PIX_W-1:0] seqv [10];
    logic [ROW_W-1:0] want1;
    for (int k = 0; k < 6; k++) seqv[k] = pix(k);
    for (int k = 6; k < 10; k++) seqv[k] = 32'hA5A5A500 + PIX_W'(k - 6);
    want1 = {seqv[6], seqv[7], seqv[8], seqv[9]};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      pix_valid = 1'b1;
      pix_data  = seqv[k];
      pix_sof   = (k == 0 || k == 6);
      tick();
      if (frame_err) pulses++;
      if (k == 6) begin
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL sof_err_pulse: got %b want 1", frame_err); end
      end
      if (k == 7) begin
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL sof_err_width: got %b want 0", frame_err); end
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    row_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (row_valid && row_ready) begin
        r.data = row_data; r.idx = row_index; r.last = row_last;
        got.push_back(r);
      end
      tick();
      if (frame_err) pulses++;
    end
    row_ready = 1'b0;
    tests++; if (pulses != 1) begin fails++; $display("FAIL sof_pulse_count: got %0d want 1", pulses); end
    tests++; if (got.size() != 2) begin fails++; $display("FAIL sof_row_count: got %0d want 2", got.size()); end
    if (got.size() >= 2) begin
      tests++; if (got[0].data !== seq_row(0) || got[0].idx !== 2'd0) begin fails++; $display("FAIL sof_queued_row: got idx %0d data %h want idx 0 data %h", got[0].idx, got[0].data, seq_row(0)); end
      tests++; if (got[1].data !== want1 || got[1].idx !== 2'd0 || got[1].last !== 1'b0) begin fails++; $display("FAIL sof_restart_row: got idx %0d last %b data %h want idx 0 last 0 data %h", got[1].idx, got[1].last, got[1].data, want1); end
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    int seen = 0;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      pix_valid = 1'b1;
      pix_data  = pix(n);
      pix_sof   = (n == 0);
      tick();
    end
    tests++; if (row_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid: got %b want 1", row_valid); end
    #2 RST = 1'b1;
    #1;
    tests++; if (row_valid !== 1'b0) begin fails++; $display("FAIL arst_row_valid: got %b want 0", row_valid); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL arst_pix_ready: got %b want 1", pix_ready); end
    tests++; if (row_index !== '0 || row_last !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL arst_tags: got idx %0d last %b err %b want 0 0 0", row_index, row_last, frame_err); end
    pix_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    row_ready = 1'b1;
    for (int n = 0; n < 7; n++) begin
      pix_valid = (n < 4);
      pix_data  = pix(20 + n);
      pix_sof   = 1'b0;
      if (row_valid && row_ready) begin
        seen++;
        tests++; if (row_index !== 2'd0 || row_data !== seq_row(20)) begin fails++; $display("FAIL arst_next_frame: got idx %0d data %h want idx 0 data %h", row_index, row_data, seq_row(20)); end
      end
      tick();
      if (frame_err) pulses++;
    end
    row_ready = 1'b0;
    pix_valid = 1'b0;
    tests++; if (seen != 1) begin fails++; $display("FAIL arst_rows_seen: got %0d want 1", seen); end
    tests++; if (pulses != 0) begin fails++; $display("FAIL arst_no_sof_err: got %0d want 0", pulses); end
  endtask

  task automatic test_random();
    int   sent = 0;
    int   cyc = 0;
    int   rows = 0;
    row_t e;
    do_reset();
    while (!(sent == 60 && exp_q.size() == 0) && cyc < 3000) begin
      pix_valid = (sent < 60) && ($urandom_range(0, 9) < 7);
      pix_data  = $urandom;
      pix_sof   = pix_valid && ((sent % 12 == 0) || sent == 17);
      row_ready = ($urandom_range(0, 1) == 1);
      tests++; if (pix_ready !== (exp_q.size() < 2)) begin fails++; $display("FAIL rnd_pix_ready @%0d: got %b want %b", cyc, pix_ready, (exp_q.size() < 2)); end
      tests++; if (row_valid !== (exp_q.size() > 0)) begin fails++; $display("FAIL rnd_row_valid @%0d: got %b want %b", cyc, row_valid, (exp_q.size() > 0)); end
      tests++; if (frame_err !== exp_err) begin fails++; $display("FAIL rnd_frame_err @%0d: got %b want %b", cyc, frame_err, exp_err); end
      if (row_valid && row_ready && exp_q.size() > 0) begin
        e = exp_q[0];
        rows++;
        tests++; if (row_data !== e.data) begin fails++; $display("FAIL rnd_row_data @%0d: got %h want %h", cyc, row_data, e.data); end
        tests++; if (row_index !== e.idx || row_last !== e.last) begin fails++; $display("FAIL rnd_row_tag @%0d: got idx %0d last %b want idx %0d last %b", cyc, row_index, row_last, e.idx, e.last); end
      end
      if (pix_valid && (exp_q.size() < 2)) sent++;
      tick();
      cyc++;
    end
    pix_valid = 1'b0;
    row_ready = 1'b0;
    tests++; if (cyc >= 3000) begin fails++; $display("FAIL rnd_timeout: got %0d cycles want < 3000", cyc); end
    tests++; if (rows < 13) begin fails++; $display("FAIL rnd_rows_delivered: got %0d want >= 13", rows); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_simultaneous();
    test_sof_resync();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
